// File: rtl/serial_mod_remainder.sv
// serial_mod_remainder: running remainder (mod MOD) of a serial bit stream.
// A frame begins with i_start, which clears the accumulator and latches the
// bit order. MSB-first frames shift each bit in at the LSB; LSB-first frames
// add each bit at a doubling weight that is itself kept reduced mod MOD.
// Only compare/subtract steps are used, so there is no divider or multiplier.
//
// Handshake: a bit is transferred on a rising edge where i_in_valid and
// o_in_ready are both high. o_in_ready depends on registered state only.
// i_start takes priority, so a bit offered in the same cycle is dropped.
module serial_mod_remainder #(
  parameter int MOD = 7,
  parameter int MAX_BITS = 32,
  localparam int RW = $clog2(MOD),
  localparam int CW = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_dir,
  input  logic          i_in_valid,
  input  logic          i_in_bit,
  output logic          o_in_ready,
  output logic [RW-1:0] o_rem,
  output logic          o_divisible,
  output logic [CW-1:0] o_bit_count,
  output logic          o_frame_done,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // The modulus is compared against values one bit wider than the remainder.
  localparam logic [RW:0]   MOD_X = (RW + 1)'(MOD);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BITS);
  localparam logic [RW-1:0] ONE_W = RW'(1);

  state_t        r_state;
  state_t        w_state_next;
  logic [RW-1:0] r_rem;
  logic [RW-1:0] w_rem_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [RW-1:0] r_weight;
  logic [RW-1:0] w_weight_next;
  logic          r_mode;
  logic          w_mode_next;
  logic          r_done;
  logic          w_done_next;
  logic          w_accept;
  logic [RW:0]   w_t;
  logic [RW:0]   w_w2;

  assign w_accept = (r_state == S_ACCUM) && i_in_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-datapath values; start outranks an offered bit.
  always_comb begin
    w_state_next  = r_state;
    w_rem_next    = r_rem;
    w_cnt_next    = r_cnt;
    w_weight_next = r_weight;
    w_mode_next   = r_mode;
    w_done_next   = 1'b0;
    w_t           = '0;
    w_w2          = '0;
    if (i_start) begin
      w_state_next  = S_ACCUM;
      w_rem_next    = '0;
      w_cnt_next    = '0;
      w_weight_next = ONE_W;
      w_mode_next   = i_dir;
    end else if (w_accept) begin
      if (!r_mode) begin
        // MSB-first: value' = 2*value + bit.
        w_t = {r_rem, i_in_bit};
      end else begin
        // LSB-first: value' = value + bit * 2^count, with 2^count held mod MOD.
        w_t = {1'b0, r_rem} + (i_in_bit ? {1'b0, r_weight} : '0);
        w_w2 = {r_weight, 1'b0};
        w_weight_next = (w_w2 >= MOD_X) ? RW'(w_w2 - MOD_X) : w_w2[RW-1:0];
      end
      // Both sums are below 2*MOD, so one conditional subtract reduces them.
      w_rem_next = (w_t >= MOD_X) ? RW'(w_t - MOD_X) : w_t[RW-1:0];
      w_cnt_next = r_cnt + CW'(1);
      if (w_cnt_next == MAX_C) begin
        w_state_next = S_FULL;
        w_done_next  = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_cnt    <= '0;
      r_weight <= ONE_W;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rem    <= w_rem_next;
      r_cnt    <= w_cnt_next;
      r_weight <= w_weight_next;
      r_mode   <= w_mode_next;
      r_done   <= w_done_next;
    end
  end

  assign o_in_ready   = (r_state == S_ACCUM);
  assign o_rem        = r_rem;
  assign o_bit_count  = r_cnt;
  assign o_divisible  = (r_rem == '0) && (r_state != S_IDLE);
  // A start in the cycle right after the frame fills suppresses the pulse.
  assign o_frame_done = r_done && !i_start;
  assign o_state      = r_state;

endmodule

// File: tb/tb_serial_mod_remainder.sv
// Bench for serial_mod_remainder: directed MOD=7/MAX_BITS=8 scenarios plus
// random 8-bit frames on seven moduli with MAX_BITS=16.
module tb_serial_mod_remainder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main instance (MOD=7, MAX_BITS=8) ----------------
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_ready;
  logic [2:0] rem;
  logic       divisible;
  logic [3:0] bit_count;
  logic       frame_done;
  logic [1:0] state;

  serial_mod_remainder #(.MOD(7), .MAX_BITS(8)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_dir(dir),
    .i_in_valid(in_valid), .i_in_bit(in_bit), .o_in_ready(in_ready),
    .o_rem(rem), .o_divisible(divisible), .o_bit_count(bit_count),
    .o_frame_done(frame_done), .o_state(state)
  );

  // ---------------- random instances (MAX_BITS=16) ----------------
  function automatic int mod_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 4;
      3: return 5;
      4: return 7;
      5: return 10;
      default: return 1023;
    endcase
  endfunction

  logic       rs_start = 1'b0;
  logic       rs_dir = 1'b0;
  logic       rs_valid = 1'b0;
  logic       rs_bit = 1'b0;
  logic [9:0] g_rem [7];
  logic       g_div [7];
  logic [4:0] g_cnt [7];
  logic       g_ready [7];
  logic       g_done [7];
  logic [1:0] g_state [7];

  for (genvar g = 0; g < 7; g++) begin : g_rnd
    localparam int M = mod_of(g);
    localparam int RWG = $clog2(M);
    logic [RWG-1:0] w_rem;
    serial_mod_remainder #(.MOD(M), .MAX_BITS(16)) u_rnd (
      .clk(clk), .rst(rst), .i_start(rs_start), .i_dir(rs_dir),
      .i_in_valid(rs_valid), .i_in_bit(rs_bit), .o_in_ready(g_ready[g]),
      .o_rem(w_rem), .o_divisible(g_div[g]), .o_bit_count(g_cnt[g]),
      .o_frame_done(g_done[g]), .o_state(g_state[g])
    );
    assign g_rem[g] = 10'(w_rem);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [2:0]  exp_q[$];
  logic [3:0]  cnt_q[$];
  logic [15:0] rval_q[$];
  logic [4:0]  rcnt_q[$];
  int   m_val;
  int   m_cnt;
  logic m_mode;

  // ---------------- driver tasks (inputs change on the falling edge) -------
  task automatic do_start(input logic d);
    start = 1'b1;
    dir = d;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    m_val = 0;
    m_cnt = 0;
    m_mode = d;
    exp_q.delete();
    cnt_q.delete();
  endtask

  // Offers one bit for one edge; the reference value is a plain integer.
  task automatic drive_accept(input logic b);
    in_valid = 1'b1;
    in_bit = b;
    if (!m_mode) m_val = m_val * 2 + int'(b);
    else         m_val = m_val + (int'(b) << m_cnt);
    m_cnt++;
    exp_q.push_back(3'(m_val % 7));
    cnt_q.push_back(4'(m_cnt));
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    n_checks++; if (rem !== 3'd0) $display("FAIL reset_rem: got %0d expected 0", rem); else n_pass++;
    n_checks++; if (bit_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", bit_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (divisible !== 1'b0) $display("FAIL reset_div: got %b expected 0", divisible); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", frame_done); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    // IDLE ignores offered bits.
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (bit_count !== 4'd0) $display("FAIL idle_count: got %0d expected 0", bit_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL idle_ready: got %b expected 0", in_ready); else n_pass++;
  endtask

  task automatic test_msb_first;
    logic b4 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] e;
    logic [3:0] c;
    do_start(1'b0);
    n_checks++; if (rem !== 3'd0) $display("FAIL msb_start_rem: got %0d expected 0", rem); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL msb_start_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (divisible !== 1'b1) $display("FAIL msb_start_div: got %b expected 1", divisible); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive_accept(b4[i]);
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      n_checks++; if (rem !== e) $display("FAIL msb_rem[%0d]: got %0d expected %0d", i, rem, e); else n_pass++;
      n_checks++; if (bit_count !== c) $display("FAIL msb_count[%0d]: got %0d expected %0d", i, bit_count, c); else n_pass++;
      n_checks++; if (divisible !== (e == 3'd0)) $display("FAIL msb_div[%0d]: got %b expected %b", i, divisible, e == 3'd0); else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  // Eight back-to-back LSB-first bits fill the frame.
  task automatic test_lsb_full;
    logic b8 [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] e;
    logic [3:0] c;
    do_start(1'b1);
    for (int i = 0; i < 8; i++) begin
      drive_accept(b8[i]);
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      n_checks++; if (rem !== e) $display("FAIL lsb_rem[%0d]: got %0d expected %0d", i, rem, e); else n_pass++;
      n_checks++; if (bit_count !== c) $display("FAIL lsb_count[%0d]: got %0d expected %0d", i, bit_count, c); else n_pass++;
      n_checks++; if (frame_done !== (i == 7)) $display("FAIL lsb_done[%0d]: got %b expected %b", i, frame_done, i == 7); else n_pass++;
      n_checks++; if (in_ready !== (i != 7)) $display("FAIL lsb_ready[%0d]: got %b expected %b", i, in_ready, i != 7); else n_pass++;
    end
    in_valid = 1'b1;
    in_bit = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (rem !== 3'(m_val % 7)) $display("FAIL full_rem[%0d]: got %0d expected %0d", i, rem, m_val % 7); else n_pass++;
      n_checks++; if (bit_count !== 4'd8) $display("FAIL full_count[%0d]: got %0d expected 8", i, bit_count); else n_pass++;
      n_checks++; if (frame_done !== 1'b0) $display("FAIL full_done[%0d]: got %b expected 0", i, frame_done); else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gap;
    logic [2:0] e;
    do_start(1'b0);
    drive_accept(1'b1);
    e = exp_q.pop_front();
    void'(cnt_q.pop_front());
    n_checks++; if (rem !== e) $display("FAIL gap_first: got %0d expected %0d", rem, e); else n_pass++;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rem !== 3'(m_val % 7)) $display("FAIL gap_hold_rem[%0d]: got %0d expected %0d", i, rem, m_val % 7); else n_pass++;
      n_checks++; if (bit_count !== 4'(m_cnt)) $display("FAIL gap_hold_count[%0d]: got %0d expected %0d", i, bit_count, m_cnt); else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      drive_accept(1'b1);
      e = exp_q.pop_front();
      void'(cnt_q.pop_front());
      n_checks++; if (rem !== e) $display("FAIL gap_rem[%0d]: got %0d expected %0d", i, rem, e); else n_pass++;
      n_checks++; if (divisible !== (e == 3'd0)) $display("FAIL gap_div[%0d]: got %b expected %b", i, divisible, e == 3'd0); else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_mid_frame;
    logic b3 [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0] e;
    do_start(1'b0);
    drive_accept(1'b1);
    drive_accept(1'b1);
    exp_q.delete();
    cnt_q.delete();
    start = 1'b1;
    dir = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_val = 0;
    m_cnt = 0;
    m_mode = 1'b1;
    n_checks++; if (rem !== 3'd0) $display("FAIL mid_start_rem: got %0d expected 0", rem); else n_pass++;
    n_checks++; if (bit_count !== 4'd0) $display("FAIL mid_start_count: got %0d expected 0", bit_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_start_ready: got %b expected 1", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_accept(b3[i]);
      e = exp_q.pop_front();
      void'(cnt_q.pop_front());
      n_checks++; if (rem !== e) $display("FAIL mid_lsb_rem[%0d]: got %0d expected %0d", i, rem, e); else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    do_start(1'b0);
    drive_accept(1'b1);
    drive_accept(1'b1);
    exp_q.delete();
    cnt_q.delete();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rem !== 3'd0) $display("FAIL arst_rem: got %0d expected 0", rem); else n_pass++;
    n_checks++; if (bit_count !== 4'd0) $display("FAIL arst_count: got %0d expected 0", bit_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL arst_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (state !== 2'd0) $display("FAIL arst_state: got %0d expected 0", state); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (bit_count !== 4'd0) $display("FAIL arst_idle_count[%0d]: got %0d expected 0", i, bit_count); else n_pass++;
      n_checks++; if (rem !== 3'd0) $display("FAIL arst_idle_rem[%0d]: got %0d expected 0", i, rem); else n_pass++;
    end
    in_valid = 1'b0;
    do_start(1'b0);
    drive_accept(1'b1);
    n_checks++; if (rem !== exp_q[0]) $display("FAIL arst_restart_rem: got %0d expected %0d", rem, exp_q[0]); else n_pass++;
    void'(exp_q.pop_front());
    void'(cnt_q.pop_front());
    in_valid = 1'b0;
  endtask

  task automatic test_random;
    int   val;
    int   cnt;
    int   cyc;
    logic d;
    logic [15:0] ev;
    logic [4:0]  ec;
    for (int f = 0; f < 6; f++) begin
      d = f[0];
      rs_start = 1'b1;
      rs_dir = d;
      rs_valid = 1'b0;
      @(negedge clk);
      rs_start = 1'b0;
      val = 0;
      cnt = 0;
      cyc = 0;
      for (int g = 0; g < 7; g++) begin
        n_checks++; if (g_state[g] !== 2'd1 || g_rem[g] !== 10'd0 || g_cnt[g] !== 5'd0)
          $display("FAIL rnd_start[m%0d]: got state %0d rem %0d count %0d expected 1 0 0", mod_of(g), g_state[g], g_rem[g], g_cnt[g]);
        else n_pass++;
      end
      while (cnt < 8 && cyc < 40) begin
        rs_valid = ($urandom_range(0, 3) != 0);
        rs_bit = 1'($urandom_range(0, 1));
        if (rs_valid) begin
          if (!d) val = val * 2 + int'(rs_bit);
          else    val = val + (int'(rs_bit) << cnt);
          cnt++;
        end
        rval_q.push_back(16'(val));
        rcnt_q.push_back(5'(cnt));
        @(negedge clk);
        cyc++;
        ev = rval_q.pop_front();
        ec = rcnt_q.pop_front();
        for (int g = 0; g < 7; g++) begin
          n_checks++; if (g_rem[g] !== 10'(int'(ev) % mod_of(g)))
            $display("FAIL rnd_rem[m%0d f%0d]: got %0d expected %0d", mod_of(g), f, g_rem[g], int'(ev) % mod_of(g));
          else n_pass++;
          n_checks++; if (g_div[g] !== (int'(ev) % mod_of(g) == 0))
            $display("FAIL rnd_div[m%0d f%0d]: got %b expected %b", mod_of(g), f, g_div[g], int'(ev) % mod_of(g) == 0);
          else n_pass++;
          n_checks++; if (g_cnt[g] !== ec || g_ready[g] !== 1'b1 || g_done[g] !== 1'b0)
            $display("FAIL rnd_ctl[m%0d f%0d]: got count %0d ready %b done %b expected %0d 1 0", mod_of(g), f, g_cnt[g], g_ready[g], g_done[g], ec);
          else n_pass++;
        end
      end
      rs_valid = 1'b0;
      n_checks++; if (cnt != 8) $display("FAIL rnd_budget[f%0d]: got %0d bits expected 8", f, cnt); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_msb_first();
    test_lsb_full();
    test_gap();
    test_start_mid_frame();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
